// File: rtl/dwbuart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// dwbuart_tx_fifo_if
//
// Groups the push side (DWBUART register block) and the frame side (UART
// transmit frontend) of the transmit byte queue into one bundle.
//
// Parameters:
//   DEPTH : number of byte entries of the attached queue (power of two, >= 2).
//           Must match the DEPTH of the dwbuart_tx_fifo it is connected to.
//
// Signals (direction as seen by the queue, i.e. the slave modport):
//   flush_i      in   synchronous clear from a UART_CR write
//   push_i       in   enqueue request, one byte per cycle
//   push_data_i  in   byte to enqueue
//   full_o       out  queue holds DEPTH entries
//   empty_o      out  queue holds 0 entries
//   level_o      out  current entry count, 0..DEPTH
//   overflow_o   out  one-cycle pulse when a push is dropped
//   idle_o       out  queue empty and no frame in flight (SR.TXE)
//   transmit_o   out  one-cycle launch pulse to the frontend
//   dr_o         out  byte being transmitted
//   done_i       in   one-cycle pulse from the frontend at end of frame
//
// Modports:
//   slave  : the queue itself
//   master : the surrounding logic (register block + transmit frontend)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface dwbuart_tx_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          push_i;
  logic [7:0]    push_data_i;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          idle_o;
  logic          transmit_o;
  logic [7:0]    dr_o;
  logic          done_i;

  modport slave (
    input  flush_i, push_i, push_data_i, done_i,
    output full_o, empty_o, level_o, overflow_o, idle_o, transmit_o, dr_o
  );

  modport master (
    output flush_i, push_i, push_data_i, done_i,
    input  full_o, empty_o, level_o, overflow_o, idle_o, transmit_o, dr_o
  );
endinterface : dwbuart_tx_fifo_if

// File: rtl/dwbuart_tx_fifo.sv
// -----------------------------------------------------------------------------
// dwbuart_tx_fifo
//
// Transmit byte queue between the DWBUART register block and the UART transmit
// frontend. Every UART_TXDR write is pushed as one byte; the queue launches one
// frame at a time (transmit_o pulse + dr_o) and waits for the frontend's done
// pulse before launching the next. Full/empty/level/idle status feeds SR.TXE
// and software flow control.
//
// Parameters:
//   DEPTH : number of byte entries, power of two, >= 2 (default 8)
//   LW    : width of level_o, derived as $clog2(DEPTH)+1; not overridden
//
// Ports:
//   clk_i : clock
//   rst_i : asynchronous reset, ACTIVE LOW despite the name
//   bus   : dwbuart_tx_fifo_if.slave (see the interface file for signals)
//
// Build option:
//   DWBUART_TX_FIFO_CHAIN_EN : when defined, a done pulse with bytes still
//   queued launches the next frame on the same edge (1-cycle gap) and the FSM
//   stays BUSY. When undefined, BUSY always returns to IDLE on done and the
//   next launch comes one edge later (2-cycle gap).
//
// All outputs are registers or decodes of registers; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dwbuart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dwbuart_tx_fifo_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("dwbuart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] cnt_q;

  // Control
  state_e        state_q;
  state_e        state_d;
  logic          pop;
  logic          push_ok;
  logic          overflow_d;

  // Registered outputs
  logic          transmit_q;
  logic          overflow_q;
  logic [7:0]    dr_q;

  logic          full;
  logic          empty;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state / pop / push-accept decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the if/case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    push_ok    = 1'b0;
    overflow_d = 1'b0;

    if (bus.flush_i) begin
      // Flush wins over launch, done and push alike.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.done_i) begin
`ifdef DWBUART_TX_FIFO_CHAIN_EN
            // Back-to-back frames: relaunch on the done edge itself.
            if (!empty) begin
              pop     = 1'b1;
              state_d = ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A same-cycle pop frees the slot the push needs, even when full.
      push_ok    = bus.push_i && (!full || pop);
      overflow_d = bus.push_i && full && !pop;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; entries are only ever read after being
  // written, and leaving them unreset lets it map onto plain flops/LUT-RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wp_q] <= bus.push_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and count
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      transmit_q <= 1'b0;
      overflow_q <= 1'b0;
      dr_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      // pop is already forced low by flush, so both pulses clear on flush.
      transmit_q <= pop;
      overflow_q <= overflow_d;
      // dr_o holds across flush and until the next launch.
      if (pop) begin
        dr_q <= mem_q[rp_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.level_o    = cnt_q;
  assign bus.overflow_o = overflow_q;
  assign bus.idle_o     = (state_q == ST_IDLE) && empty;
  assign bus.transmit_o = transmit_q;
  assign bus.dr_o       = dr_q;

endmodule : dwbuart_tx_fifo
